imem_loader: RTL and testbench

- Hardware writer for the single-cycle MIPS instruction memory; the synthesizable counterpart to the `$readmemh` preload the CPU relies on in simulation.
- Accepts a length-prefixed big-endian byte stream on a valid/ready handshake and assembles 32-bit words.
- Writes each word to consecutive instruction-memory word addresses from 0.
- Holds the CPU in reset until a complete, valid image has been written.

---
 rtl/mips_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 32 +++
 rtl/byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory loader: loader states,
// instruction width and the default instruction-memory word-address width.
package mips_pkg;

    localparam int INSTR_W     = 32;
    localparam int IMEM_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        FIN,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus of the loader.
// The stream source and memory sink use master; the loader uses slave.
interface imem_loader_if #(
    parameter int ADDR_W = mips_pkg::IMEM_ADDR_W
);

    logic                        in_valid;
    logic [7:0]                  in_data;
    logic                        in_ready;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [mips_pkg::INSTR_W-1:0] mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/byte_packer.sv
// Shifts four accepted bytes big-endian into one 32-bit instruction word;
// word_valid is high in the cycle the fourth byte is accepted.
module byte_packer
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [1:0]  count_q, count_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        if (clear) begin
            count_d = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            count_d = count_q + 2'd1;
            shift_d = {shift_q[15:0], byte_data};
        end
    end

    // The fourth byte is taken straight from the input so the word is
    // available in the same cycle it completes.
    assign word_valid = byte_valid && (count_q == 2'd3);
    assign word       = {shift_q, byte_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            shift_q <= '0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory and
// holds the CPU in reset until done. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int LEN_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic          busy
);

    localparam logic [LEN_W:0] CAPACITY = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W:0]     word_idx_q, word_idx_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif

    logic               in_ready;
    logic               fire;
    logic               start_ok;
    logic               word_valid;
    logic [INSTR_W-1:0] word;
    logic [LEN_W-1:0]   next_len;
    logic [LEN_W:0]     word_idx_inc;

    // in_ready is a pure state decode, so it never depends on in_valid.
    assign in_ready     = state_q inside {LEN_HI, LEN_LO, DATA, CHK};
    assign fire         = bus.in_valid && in_ready;
    assign start_ok     = start && (state_q inside {IDLE, DONE, ERR});
    assign next_len     = {len_q[LEN_W-9:0], bus.in_data};
    assign word_idx_inc = word_idx_q + 1'b1;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (fire && (state_q == DATA)),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN_HI;
                    len_d      = '0;
                    word_idx_d = '0;
                    mem_addr_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            LEN_HI: begin
                if (fire) begin
                    len_d   = next_len;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (fire) begin
                    len_d   = next_len;
                    state_d = ((next_len == '0) || ({1'b0, next_len} > CAPACITY)) ? ERR : DATA;
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (fire) begin
                    chk_d = chk_q ^ bus.in_data;
                end
`endif
                // A completed word is registered here and strobed next cycle;
                // the header check guarantees the index fits the address.
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = word;
                    mem_addr_d  = word_idx_q[ADDR_W-1:0];
                    word_idx_d  = word_idx_inc;
                    if (word_idx_inc == {1'b0, len_q}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = FIN;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (fire) begin
                    state_d = (bus.in_data == chk_q) ? FIN : ERR;
                end
            end
`endif
            FIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // The CPU is released only by a completed load, starting in the FIN cycle.
    assign cpu_hold = !(state_q inside {FIN, DONE});
    assign done     = (state_q == FIN);
    assign error    = (state_q == ERR);
    assign busy     = !(state_q inside {IDLE, DONE, ERR});

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads with random gaps and
// random images, checked against a word-level model of the expected writes.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_hold;
    logic done;
    logic error;
    logic busy;

    int errors = 0;
    int checks = 0;

    int          cycleNo   = 0;
    int          dueCycle  = -1;
    logic [31:0] expAddr   = '0;
    logic [31:0] expData   = '0;
    int          weCount   = 0;
    int          doneCount = 0;
    logic [31:0] lastAddr  = '0;
    logic [31:0] lastData  = '0;
    logic [7:0]  lastChk   = '0;

    logic [31:0] img[$];
    int          weBefore;
    int          doneBefore;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: a strobe is due exactly in the cycle after a word's 4th byte.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("mem_we timing", 32'(bus.mem_we), 32'(dueCycle == cycleNo));
            if (bus.mem_we && (dueCycle == cycleNo)) begin
                checkOutput("mem_addr", 32'(bus.mem_addr), expAddr);
                checkOutput("mem_wdata", bus.mem_wdata, expData);
            end
            if (bus.mem_we) begin
                weCount++;
                lastAddr = 32'(bus.mem_addr);
                lastData = bus.mem_wdata;
            end
            if (done) doneCount++;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gapMax, input bit completes,
                                 input logic [31:0] wAddr, input logic [31:0] wData);
        int g;
        int waited;
        g = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
        for (int i = 0; i < g; i++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.in_ready && waited < 50);
        if (!bus.in_ready) begin
            checkOutput("byte accept", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (completes) begin
            dueCycle = cycleNo;
            expAddr  = wAddr;
            expData  = wData;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic loadImage(input int gapMax, input int startAt, input bit badChk);
        logic [15:0] n;
        logic [7:0]  chk;
        logic [7:0]  b;
        n   = 16'(img.size());
        chk = '0;
        applyStimulus(n[15:8], gapMax, 1'b0, '0, '0);
        applyStimulus(n[7:0], gapMax, 1'b0, '0, '0);
        foreach (img[k]) begin
            if (k == startAt) pulseStart();
            for (int j = 0; j < 4; j++) begin
                b   = img[k][31-8*j -: 8];
                chk = chk ^ b;
                applyStimulus(b, gapMax, (j == 3), 32'(k), img[k]);
            end
        end
        lastChk = badChk ? (chk ^ 8'h01) : chk;
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(lastChk, gapMax, 1'b0, '0, '0);
`endif
    endtask

    task automatic checkLoaded(input string tag, input int nWords, input logic [31:0] lastWord);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, " done pulses"}, 32'(doneCount - doneBefore), 32'd1);
        checkOutput({tag, " write count"}, 32'(weCount - weBefore), 32'(nWords));
        checkOutput({tag, " last addr"}, lastAddr, 32'(nWords - 1));
        checkOutput({tag, " last data"}, lastData, lastWord);
        checkOutput({tag, " cpu_hold"}, 32'(cpu_hold), 32'd0);
        checkOutput({tag, " error"}, 32'(error), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
        checkOutput({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
        checkOutput({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
        checkOutput({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
        checkOutput({tag, " cpu_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " error"}, 32'(error), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2;
        checkResetValues("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] normal load");
        img = '{32'h2008_0005, 32'h2009_000A};
        weBefore   = weCount;
        doneBefore = doneCount;
        pulseStart();
        checkOutput("start busy", 32'(busy), 32'd1);
        checkOutput("start cpu_hold", 32'(cpu_hold), 32'd1);
        loadImage(0, -1, 1'b0);
        checkLoaded("normal", 2, 32'h2009_000A);

        $display("[TB] bad headers");
        weBefore = weCount;
        pulseStart();
        applyStimulus(8'h00, 0, 1'b0, '0, '0);
        applyStimulus(8'h00, 0, 1'b0, '0, '0);
        checkOutput("zero len error", 32'(error), 32'd1);
        checkOutput("zero len cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("zero len in_ready", 32'(bus.in_ready), 32'd0);
        pulseStart();
        checkOutput("start clears error", 32'(error), 32'd0);
        checkOutput("restart busy", 32'(busy), 32'd1);
        applyStimulus(8'((CAP + 1) >> 8), 0, 1'b0, '0, '0);
        applyStimulus(8'(CAP + 1), 0, 1'b0, '0, '0);
        checkOutput("oversize error", 32'(error), 32'd1);
        checkOutput("oversize cpu_hold", 32'(cpu_hold), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bad header writes", 32'(weCount - weBefore), 32'd0);
        pulseStart();
        checkOutput("second start clears error", 32'(error), 32'd0);

        $display("[TB] gapped load");
        weBefore   = weCount;
        doneBefore = doneCount;
        loadImage(3, -1, 1'b0);
        checkLoaded("gapped", 2, 32'h2009_000A);

        $display("[TB] random image");
        img.delete();
        for (int k = 0; k < 6; k++) img.push_back($urandom);
        weBefore   = weCount;
        doneBefore = doneCount;
        pulseStart();
        loadImage(2, -1, 1'b0);
        checkLoaded("random", 6, img[5]);

        $display("[TB] reset mid-load");
        weBefore = weCount;
        pulseStart();
        applyStimulus(8'h00, 0, 1'b0, '0, '0);
        applyStimulus(8'h02, 0, 1'b0, '0, '0);
        applyStimulus(8'h20, 0, 1'b0, '0, '0);
        applyStimulus(8'h08, 0, 1'b0, '0, '0);
        applyStimulus(8'h00, 0, 1'b0, '0, '0);
        applyStimulus(8'h05, 0, 1'b1, 32'd0, 32'h2008_0005);
        applyStimulus(8'h20, 0, 1'b0, '0, '0);
        applyStimulus(8'h09, 0, 1'b0, '0, '0);
        rst = 1'b0;
        #1;
        checkResetValues("mid-load reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("mid-load writes", 32'(weCount - weBefore), 32'd1);
        img = '{32'h2008_0005, 32'h2009_000A};
        weBefore   = weCount;
        doneBefore = doneCount;
        pulseStart();
        loadImage(1, -1, 1'b0);
        checkLoaded("after reset", 2, 32'h2009_000A);

        $display("[TB] capacity load");
        img.delete();
        for (int k = 0; k < CAP; k++) img.push_back(32'(k));
        weBefore   = weCount;
        doneBefore = doneCount;
        pulseStart();
        loadImage(1, 100, 1'b0);
        checkLoaded("capacity", CAP, 32'(CAP - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] checksum");
        img = '{32'h2008_0005, 32'h2009_000A};
        weBefore   = weCount;
        doneBefore = doneCount;
        pulseStart();
        loadImage(0, -1, 1'b0);
        checkLoaded("good checksum", 2, 32'h2009_000A);
        weBefore   = weCount;
        doneBefore = doneCount;
        pulseStart();
        loadImage(0, -1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bad checksum error", 32'(error), 32'd1);
        checkOutput("bad checksum cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("bad checksum done", 32'(doneCount - doneBefore), 32'd0);
        checkOutput("bad checksum writes kept", 32'(weCount - weBefore), 32'd2);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
